// File: rtl/frame_seq_pkg.sv
// ---------------------------------------------------------------------------
// frame_seq_pkg: shared states, default timing and width helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    BLANK  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam int DEF_H_ACTIVE   = 16;
  localparam int DEF_V_ACTIVE   = 16;
  localparam int DEF_H_BLANK    = 4;
  localparam int DEF_GAP_CYCLES = 8;
  localparam int DEF_N_MODELS   = 5;
  localparam int DEF_NUM_FRAMES = 0;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_line_counter.sv
// ---------------------------------------------------------------------------
// video_line_counter: blank+active line position counter with de/pix_x. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module video_line_counter
  import frame_seq_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  output logic                          de,
  output logic [coord_w(H_ACTIVE)-1:0]  pix_x,
  output logic                          blank_end,
  output logic                          line_end
);

  localparam int LINE_LEN = H_BLANK + H_ACTIVE;
  localparam int HW       = coord_w(LINE_LEN);
  localparam int XW       = coord_w(H_ACTIVE);

  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;
  logic          last;
  logic          nxt_active;

  assign last       = (hcnt == HW'(LINE_LEN - 1));
  assign line_end   = enable && last;
  assign blank_end  = enable && (hcnt == HW'(H_BLANK - 1));
  assign hcnt_nxt   = last ? '0 : hcnt + 1'b1;
  assign nxt_active = (hcnt_nxt >= HW'(H_BLANK));

  // de/pix_x are registered from the next position so they line up with hcnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= '0;
      de    <= 1'b0;
      pix_x <= '0;
    end else if (clear) begin
      hcnt  <= '0;
      de    <= 1'b0;
      pix_x <= '0;
    end else if (enable) begin
      hcnt  <= hcnt_nxt;
      de    <= nxt_active;
      pix_x <= nxt_active ? XW'(hcnt_nxt - HW'(H_BLANK)) : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer: frame timing generator with round-robin model select. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int N_MODELS   = DEF_N_MODELS,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES
) (
  input  logic                          vga_clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  output logic                          vga_vs,
  output logic                          vga_de,
  output logic [coord_w(H_ACTIVE)-1:0]  pix_x,
  output logic [coord_w(V_ACTIVE)-1:0]  pix_y,
  output logic [2:0]                    model_sel,
  output logic [7:0]                    frame_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int YW = coord_w(V_ACTIVE);
  localparam int GW = coord_w(GAP_CYCLES);

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   frames_run;
  logic          stop_latched;
  logic          in_frame;
  logic          blank_end;
  logic          line_end;
  logic          run_over;

  assign in_frame = (state == BLANK) || (state == ACTIVE);
  assign run_over = stop || stop_latched ||
                    ((NUM_FRAMES != 0) && ((frames_run + 16'd1) == 16'(NUM_FRAMES)));

  video_line_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK)
  ) u_line (
    .clk       (vga_clk),
    .rst_n     (rst_n),
    .enable    (in_frame),
    .clear     (!in_frame),
    .de        (vga_de),
    .pix_x     (pix_x),
    .blank_end (blank_end),
    .line_end  (line_end)
  );

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      frames_run   <= '0;
      stop_latched <= 1'b0;
      vga_vs       <= 1'b0;
      pix_y        <= '0;
      model_sel    <= '0;
      frame_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          stop_latched <= 1'b0;
          if (start && !stop) begin
            state      <= GAP;
            busy       <= 1'b1;
            gap_cnt    <= '0;
            frames_run <= '0;
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state   <= BLANK;
            vga_vs  <= 1'b1;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        BLANK: begin
          if (stop) stop_latched <= 1'b1;
          if (blank_end) state <= ACTIVE;
        end
        ACTIVE: begin
          if (stop) stop_latched <= 1'b1;
          if (line_end) begin
            if (pix_y != YW'(V_ACTIVE - 1)) begin
              pix_y <= pix_y + 1'b1;
              state <= BLANK;
            end else begin
              // Frame end: everything that advances per frame moves while vs drops.
              pix_y      <= '0;
              vga_vs     <= 1'b0;
              frame_idx  <= frame_idx + 8'd1;
              model_sel  <= (model_sel == 3'(N_MODELS - 1)) ? 3'd0 : model_sel + 3'd1;
              frames_run <= frames_run + 16'd1;
              if (run_over) begin
                state        <= IDLE;
                busy         <= 1'b0;
                done         <= 1'b1;
                stop_latched <= 1'b0;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer: scoreboard bench for frame_sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_frame_sequencer;

  logic clk;
  logic rst_n;
  logic start_a, stop_a, start_b, stop_b;
  logic vs_a, de_a, busy_a, done_a;
  logic [3:0] pix_x_a, pix_y_a;
  logic [2:0] model_sel_a;
  logic [7:0] frame_idx_a;
  logic vs_b, de_b, busy_b, done_b;
  logic [0:0] pix_x_b, pix_y_b;
  logic [2:0] model_sel_b;
  logic [7:0] frame_idx_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_model = 0;
  int exp_fidx = 0;

  typedef struct {
    int model;
    int fidx_after;
    int model_after;
    int busy_after;
    int exp_rise;
    bit gap_check;
  } frec_t;

  typedef struct {
    int fidx;
    int model;
  } brec_t;

  frec_t fq[$];
  int    dq[$];
  brec_t bq[$];

  frame_sequencer dut_a (
    .vga_clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .vga_vs(vs_a), .vga_de(de_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .model_sel(model_sel_a), .frame_idx(frame_idx_a), .busy(busy_a), .done(done_a)
  );

  frame_sequencer #(
    .H_ACTIVE(2), .V_ACTIVE(2), .H_BLANK(1), .GAP_CYCLES(2), .N_MODELS(3), .NUM_FRAMES(1)
  ) dut_b (
    .vga_clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .vga_vs(vs_b), .vga_de(de_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .model_sel(model_sel_b), .frame_idx(frame_idx_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int exp_rise, input bit gap_check, input bit last);
    frec_t r;
    r.model       = exp_model;
    exp_model     = (exp_model + 1) % 5;
    exp_fidx      = (exp_fidx + 1) % 256;
    r.model_after = exp_model;
    r.fidx_after  = exp_fidx;
    r.busy_after  = last ? 0 : 1;
    r.exp_rise    = exp_rise;
    r.gap_check   = gap_check;
    fq.push_back(r);
  endtask

  task automatic wait_rise(output int rc);
    bit prev;
    prev = vs_a;
    rc = -1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (vs_a && !prev) begin
        rc = cyc;
        return;
      end
      prev = vs_a;
    end
    timeout_fail("vs_rise_wait");
  endtask

  task automatic wait_idle_a();
    for (int n = 0; n < 1000; n++) begin
      if (!busy_a) return;
      tick();
    end
    timeout_fail("idle_wait_a");
  endtask

  // Monitor for the default-timing instance: per-pixel order, frame shape, done pulses.
  initial begin
    int rise = 0, first_de = 0, de_cnt = 0, ex = 0, ey = 0, fm = 0, last_fall = 0;
    bit vs_prev = 1'b0, in_frame = 1'b0;
    frec_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vs_prev  = 1'b0;
        in_frame = 1'b0;
        continue;
      end
      if (done_a) begin
        chk("done_expected", dq.size() != 0, 1);
        if (dq.size() != 0) chk("done_cycle", cyc, dq.pop_front());
      end
      if (vs_a && !vs_prev) begin
        chk("frame_expected", fq.size() != 0, 1);
        chk("de_at_vs_rise", de_a, 0);
        in_frame = 1'b1;
        rise = cyc; first_de = -1; de_cnt = 0; ex = 0; ey = 0;
        fm = model_sel_a;
      end
      if (vs_a) begin
        chk("model_stable", model_sel_a, fm);
        if (de_a) begin
          if (first_de < 0) first_de = cyc;
          chk("pix_x", pix_x_a, ex);
          chk("pix_y", pix_y_a, ey);
          de_cnt++;
          if (ex == 15) begin ex = 0; ey++; end
          else ex++;
        end else begin
          chk("pix_x_blank", pix_x_a, 0);
        end
      end else begin
        chk("de_outside_vs", de_a, 0);
        chk("pix_y_outside_vs", pix_y_a, 0);
      end
      if (!vs_a && vs_prev && in_frame) begin
        in_frame = 1'b0;
        if (fq.size() != 0) begin
          r = fq.pop_front();
          chk("vs_len", cyc - rise, 320);
          chk("de_count", de_cnt, 256);
          chk("first_de_offset", first_de - rise, 4);
          chk("frame_model", fm, r.model);
          chk("frame_idx_after", frame_idx_a, r.fidx_after);
          chk("model_sel_after", model_sel_a, r.model_after);
          chk("busy_after", busy_a, r.busy_after);
          if (r.exp_rise >= 0) chk("vs_rise_cycle", rise, r.exp_rise);
          if (r.gap_check) chk("gap_len", rise - last_fall, 8);
        end
        last_fall = cyc;
      end
      vs_prev = vs_a;
    end
  end

  // Monitor for the small single-frame instance: judged at each done pulse.
  initial begin
    int vc = 0, dc = 0, rc = 0;
    bit vp = 1'b0;
    brec_t br;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vc = 0; dc = 0; rc = 0; vp = 1'b0;
        continue;
      end
      if (vs_b) vc++;
      if (de_b) dc++;
      if (vs_b && !vp) rc++;
      if (done_b) begin
        chk("b_done_expected", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          br = bq.pop_front();
          chk("b_frame_idx", frame_idx_b, br.fidx);
          chk("b_model_sel", model_sel_b, br.model);
          chk("b_de_count", dc, 4);
          chk("b_vs_cycles", vc, 6);
          chk("b_vs_rises", rc, 1);
          chk("b_busy", busy_b, 0);
        end
        vc = 0; dc = 0; rc = 0;
      end
      vp = vs_b;
    end
  end

  initial begin
    #2_000_000;
    timeout_fail("global_watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int t, r;
    rst_n = 1'b0; start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    repeat (3) tick();
    chk("rst_vs", vs_a, 0);
    chk("rst_de", de_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_model_sel", model_sel_a, 0);
    chk("rst_frame_idx", frame_idx_a, 0);
    chk("rst_pix_x", pix_x_a, 0);
    chk("rst_pix_y", pix_y_a, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Continuous run of 12 frames, start pulses while busy, stop in line 7 of the last.
    t = cyc;
    push_frame(t + 9, 1'b0, 1'b0);
    for (int i = 1; i < 11; i++) push_frame(-1, 1'b1, 1'b0);
    push_frame(-1, 1'b1, 1'b1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("busy_after_start", busy_a, 1);
    for (int k = 1; k <= 12; k++) begin
      wait_rise(r);
      if (k == 3) begin
        repeat (50) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (272) tick();
        chk("in_gap_before_pulse", vs_a, 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
      end
    end
    repeat (150) tick();
    dq.push_back(r + 320);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    wait_idle_a();
    repeat (400) tick();
    chk("no_vs_after_stop", vs_a, 0);
    chk("idle_busy", busy_a, 0);

    // Stop during the first gap: done next cycle, vs never rises.
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (2) tick();
    chk("gap_busy", busy_a, 1);
    dq.push_back(cyc + 1);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("gap_stop_busy", busy_a, 0);
    chk("gap_stop_frame_idx", frame_idx_a, 12);
    chk("gap_stop_model_sel", model_sel_a, 2);
    repeat (40) tick();
    chk("gap_stop_no_vs", vs_a, 0);

    // start and stop together in IDLE: nothing happens.
    start_a = 1'b1; stop_a = 1'b1; tick(); start_a = 1'b0; stop_a = 1'b0;
    chk("startstop_busy", busy_a, 0);
    repeat (30) tick();
    chk("startstop_busy_late", busy_a, 0);

    // Asynchronous reset mid-line.
    t = cyc;
    push_frame(t + 9, 1'b0, 1'b0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_rise(r);
    repeat (70) tick();
    chk("pre_reset_de", de_a, 1);
    chk("pre_reset_model_sel", model_sel_a, 2);
    #1 rst_n = 1'b0;
    fq.delete();
    #1;
    chk("async_vs", vs_a, 0);
    chk("async_de", de_a, 0);
    chk("async_busy", busy_a, 0);
    chk("async_model_sel", model_sel_a, 0);
    chk("async_frame_idx", frame_idx_a, 0);
    chk("async_pix_x", pix_x_a, 0);
    chk("async_pix_y", pix_y_a, 0);
    exp_model = 0;
    exp_fidx = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    t = cyc;
    push_frame(t + 9, 1'b0, 1'b1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_rise(r);
    repeat (150) tick();
    dq.push_back(r + 320);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    wait_idle_a();
    repeat (5) tick();

    // Single-frame runs on the small instance until frame_idx wraps past 255.
    for (int k = 0; k < 256; k++) begin
      brec_t br;
      br.fidx  = (k + 1) % 256;
      br.model = (k + 1) % 3;
      bq.push_back(br);
      start_b = 1'b1; tick(); start_b = 1'b0;
      for (int n = 0; n <= 30; n++) begin
        if (!busy_b) break;
        if (n == 30) timeout_fail("idle_wait_b");
        tick();
      end
      tick();
    end
    chk("b_wrapped_frame_idx", frame_idx_b, 0);

    repeat (5) tick();
    chk("frames_pending", fq.size(), 0);
    chk("dones_pending", dq.size(), 0);
    chk("b_pending", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
